// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and requantize helper for the CNN datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  localparam int unsigned c_SAT_W = 64;

  // ReLU, arithmetic right shift, then clamp to the positive range of a dw-bit signed value.
  function automatic logic signed [c_SAT_W-1:0] sat_relu_shift(
    input logic signed [c_SAT_W-1:0] acc,
    input int unsigned               shift,
    input int unsigned               dw
  );
    logic signed [c_SAT_W-1:0] v;
    logic signed [c_SAT_W-1:0] q;
    logic signed [c_SAT_W-1:0] lim;
    v   = (acc < 0) ? 64'sd0 : acc;
    q   = v >>> shift;
    lim = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return (q > lim) ? lim : q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool
// Description : Streaming ReLU + 2x2/stride-2 max-pool + requantize of a conv output map.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_H       = 4,
  parameter int unsigned IN_W       = 4,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  input  logic signed [ACC_WIDTH-1:0]  in_pixel,
  input  logic                         in_valid,
  output logic        [DATA_WIDTH-1:0] out_pixel,
  output logic                         out_valid,
  output logic                         out_last
);

  localparam int unsigned c_CW   = $clog2(IN_W) + 1;
  localparam int unsigned c_RW   = $clog2(IN_H) + 1;
  localparam int unsigned c_IW   = c_CW - 1;
  localparam int unsigned c_NBUF = IN_W / 2;
  localparam int unsigned c_PW   = IN_W / 2;
  localparam int unsigned c_PH   = IN_H / 2;

  localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(IN_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(IN_H - 1);
  localparam logic [c_CW-1:0] c_COL_PLAST = c_CW'(2 * c_PW - 1);
  localparam logic [c_RW-1:0] c_ROW_PLAST = c_RW'(2 * c_PH - 1);

  pool_state_t r_state;
  pool_state_t w_state_nxt;

  logic        [c_CW-1:0]      r_col;
  logic        [c_RW-1:0]      r_row;
  logic signed [ACC_WIDTH-1:0] r_h_max;
  logic signed [ACC_WIDTH-1:0] r_rowbuf [c_NBUF];

  logic signed [ACC_WIDTH-1:0] w_relu;
  logic signed [ACC_WIDTH-1:0] w_m;
  logic signed [ACC_WIDTH-1:0] w_rb_rd;
  logic signed [ACC_WIDTH-1:0] w_win;
  logic signed [c_SAT_W-1:0]   w_win_ext;
  logic signed [c_SAT_W-1:0]   w_q;
  logic        [c_IW-1:0]      w_idx;
  logic                        w_accept;
  logic                        w_frame_end;
  logic                        w_open;
  logic                        w_emit;
  logic                        w_emit_last;
  logic                        w_buf_wr;

  assign w_accept    = (r_state == RUN) && in_valid;
  assign w_frame_end = w_accept && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  assign w_open      = start && (r_state != RUN);

  assign w_relu = in_pixel[ACC_WIDTH-1] ? '0 : in_pixel;
  assign w_m    = (w_relu > r_h_max) ? w_relu : r_h_max;
  assign w_idx  = r_col[c_CW-1:1];

  always_comb begin
    w_rb_rd = '0;
    for (int unsigned i = 0; i < c_NBUF; i++) begin
      if (w_idx == c_IW'(i)) begin
        w_rb_rd = r_rowbuf[i];
      end
    end
  end

  assign w_win     = (w_rb_rd > w_m) ? w_rb_rd : w_m;
  assign w_win_ext = c_SAT_W'(w_win);
  assign w_q       = sat_relu_shift(w_win_ext, SHIFT, DATA_WIDTH);

  // Odd trailing row/column of an odd-sized map never closes a window.
  assign w_emit      = w_accept && r_col[0] && r_row[0]
                       && (r_col <= c_COL_PLAST) && (r_row <= c_ROW_PLAST);
  assign w_emit_last = w_emit && (r_row == c_ROW_PLAST) && (r_col == c_COL_PLAST);
  assign w_buf_wr    = w_accept && r_col[0] && !r_row[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)       w_state_nxt = RUN;
      RUN:     if (w_frame_end) w_state_nxt = DONE;
      DONE:    if (start)       w_state_nxt = RUN;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_h_max   <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pixel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      done      <= (w_state_nxt == DONE);
      out_valid <= w_emit;
      out_last  <= w_emit_last;
      if (w_emit) begin
        out_pixel <= w_q[DATA_WIDTH-1:0];
      end
      if (w_accept && !r_col[0]) begin
        r_h_max <= w_relu;
      end
      if (w_open) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Row buffer is always written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < c_NBUF; i++) begin
      if (w_buf_wr && (w_idx == c_IW'(i))) begin
        r_rowbuf[i] <= w_m;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool
// Description : Directed bench for relu_maxpool (4x4 SHIFT=0, 4x4 SHIFT=2, 3x3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start    [ND];
  logic              in_valid [ND];
  logic signed [31:0] in_pixel [ND];
  logic              done_o   [ND];
  logic              ov       [ND];
  logic              ol       [ND];
  logic [7:0]        op       [ND];

  relu_maxpool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .IN_H(4), .IN_W(4), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .done(done_o[0]), .in_pixel(in_pixel[0]),
    .in_valid(in_valid[0]), .out_pixel(op[0]), .out_valid(ov[0]), .out_last(ol[0]));
  relu_maxpool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .IN_H(4), .IN_W(4), .SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .done(done_o[1]), .in_pixel(in_pixel[1]),
    .in_valid(in_valid[1]), .out_pixel(op[1]), .out_valid(ov[1]), .out_last(ol[1]));
  relu_maxpool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .IN_H(3), .IN_W(3), .SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .done(done_o[2]), .in_pixel(in_pixel[2]),
    .in_valid(in_valid[2]), .out_pixel(op[2]), .out_valid(ov[2]), .out_last(ol[2]));

  function automatic int hof(int d);  return (d == 2) ? 3 : 4; endfunction
  function automatic int wof(int d);  return (d == 2) ? 3 : 4; endfunction
  function automatic int shof(int d); return (d == 1) ? 2 : 0; endfunction

  // Frame-level model: stores the ReLU'd image and pools whole windows when they close.
  bit run_m   [ND];
  bit done_m  [ND];
  int cnt_m   [ND];
  int img     [ND][4][4];
  int last_px [ND];
  bit ev_next [ND];
  bit el_next [ND];
  bit sv [ND];
  bit sl [ND];
  bit sd [ND];
  int sp [ND];
  int got [ND][$];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int max2(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_step(input int d, input bit s, input bit v, input int p);
    int r, c, m, q, hh, ww;
    hh = hof(d);
    ww = wof(d);
    if (s && !run_m[d]) begin
      run_m[d]  = 1'b1;
      done_m[d] = 1'b0;
      cnt_m[d]  = 0;
    end else if (v && run_m[d]) begin
      r = cnt_m[d] / ww;
      c = cnt_m[d] % ww;
      img[d][r][c] = (p < 0) ? 0 : p;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = max2(max2(img[d][r-1][c-1], img[d][r-1][c]), max2(img[d][r][c-1], img[d][r][c]));
        q = m >>> shof(d);
        last_px[d] = (q > 127) ? 127 : q;
        ev_next[d] = 1'b1;
        el_next[d] = (r == 2 * (hh / 2) - 1) && (c == 2 * (ww / 2) - 1);
      end
      cnt_m[d]++;
      if (cnt_m[d] == hh * ww) begin
        run_m[d]  = 1'b0;
        done_m[d] = 1'b1;
      end
    end
  endtask

  task automatic tick(input int d, input bit s, input bit v, input int p);
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      start[i]    = (i == d) ? s : 1'b0;
      in_valid[i] = (i == d) ? v : 1'b0;
      in_pixel[i] = (i == d) ? p : 0;
    end
    if (d >= 0) model_step(d, s, v, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(-1, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_pixel[i] = 0;
      run_m[i] = 1'b0; done_m[i] = 1'b0; cnt_m[i] = 0; last_px[i] = 0;
      ev_next[i] = 1'b0; el_next[i] = 1'b0;
    end
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_lits(input int d, input int n, input int e[4]);
    check("out_count", d, got[d].size(), n);
    for (int i = 0; i < n && i < got[d].size(); i++) check("literal_out", d, got[d][i], e[i]);
    got[d].delete();
  endtask

  // Per-cycle compare: snapshot the model's post-edge view, then sample #1 after the edge.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      sv[d] = ev_next[d]; sl[d] = el_next[d]; sd[d] = done_m[d]; sp[d] = last_px[d];
      ev_next[d] = 1'b0; el_next[d] = 1'b0;
    end
    #1;
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check("out_valid", d, 32'(ov[d]), 32'(sv[d]));
        check("out_last",  d, 32'(ol[d]), 32'(sl[d]));
        check("done",      d, 32'(done_o[d]), 32'(sd[d]));
        check("out_pixel", d, 32'(op[d]), sp[d]);
        if (ov[d] === 1'b1) got[d].push_back(int'(op[d]));
      end
    end
  end

  int t3 [16] = '{1000, 2, 400, -5, 3, 4, 3, 399, 8, -1, -7, -3, 1, 5, -9, -2};

  initial begin
    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_pixel[i] = 0;
      run_m[i] = 1'b0; done_m[i] = 1'b0; cnt_m[i] = 0; last_px[i] = 0;
      ev_next[i] = 1'b0; el_next[i] = 1'b0;
    end
    do_reset();
    idle(2);

    // 1: contiguous ramp
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1'b0, 1'b1, k);
    idle(3);
    expect_lits(0, 4, '{5, 7, 13, 15});

    // 2: all negative, restart from DONE
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1'b0, 1'b1, -50);
    idle(3);
    expect_lits(0, 4, '{0, 0, 0, 0});

    // 3: SHIFT=2 clamp; in_valid together with start is ignored
    tick(1, 1'b1, 1'b1, 999);
    for (int k = 0; k < 16; k++) tick(1, 1'b0, 1'b1, t3[k]);
    idle(3);
    expect_lits(1, 4, '{127, 100, 2, 0});

    // 4: odd 3x3 map
    tick(2, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 9; k++) tick(2, 1'b0, 1'b1, k);
    idle(3);
    expect_lits(2, 1, '{5, 0, 0, 0});

    // 5: gapped input, then reset mid-frame
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) begin
      tick(0, 1'b0, 1'b1, k);
      idle(4);
    end
    idle(2);
    expect_lits(0, 4, '{5, 7, 13, 15});
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++) tick(0, 1'b0, 1'b1, k);
    idle(2);
    expect_lits(0, 1, '{5, 0, 0, 0});
    do_reset();
    idle(3);
    expect_lits(0, 0, '{0, 0, 0, 0});
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1'b0, 1'b1, k);
    idle(3);
    expect_lits(0, 4, '{5, 7, 13, 15});

    // 6: start mid-frame ignored, then start from DONE with a reversed ramp
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 8; k++) tick(0, 1'b0, 1'b1, k);
    tick(0, 1'b1, 1'b1, 8);
    for (int k = 9; k < 16; k++) tick(0, 1'b0, 1'b1, k);
    idle(3);
    expect_lits(0, 4, '{5, 7, 13, 15});
    tick(0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1'b0, 1'b1, 15 - k);
    idle(3);
    expect_lits(0, 4, '{15, 13, 7, 5});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
